// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// MemPortArbiter
// Shares the single SDRAM controller line-transfer interface between
// NUM_PORTS cache-style requesters. Each requester keeps its req level and
// command stable until it sees a one-cycle ready pulse. The arbiter latches
// the winner's command, holds it on the controller interface until
// mem_ready, then pulses the winner's ready with the registered read line.
// Arbitration is fixed priority (port 0 highest) or round-robin, chosen by
// RR_MODE.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge) and asynchronous active-low reset
//   i_port_req          per-port request level
//   i_port_wren         per-port write (1) / read (0)
//   i_port_address      packed line addresses, port i at [i*ADDR_W +: ADDR_W]
//   i_port_wdata        packed write lines, port i at [i*DATA_W +: DATA_W]
//   o_port_ready        one-cycle completion pulse, one-hot or zero
//   o_port_rdata        last read line, valid with the matching ready pulse
//   o_mem_req           request to the SDRAM controller
//   o_mem_wren          write flag to the controller
//   o_mem_address       line address to the controller
//   o_mem_wdata         write line to the controller
//   i_mem_ready         controller completion pulse
//   i_mem_rdata         read line from the controller
//   o_grant_id          index of the current or last granted port
//   o_busy              high whenever a transfer is in progress
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter  int NUM_PORTS = 2,
   parameter  int ADDR_W    = 14,
   parameter  int DATA_W    = 64,
   parameter  int RR_MODE   = 1,
   localparam int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [NUM_PORTS-1:0]        i_port_req,
   input  logic [NUM_PORTS-1:0]        i_port_wren,
   input  logic [NUM_PORTS*ADDR_W-1:0] i_port_address,
   input  logic [NUM_PORTS*DATA_W-1:0] i_port_wdata,
   output logic [NUM_PORTS-1:0]        o_port_ready,
   output logic [DATA_W-1:0]           o_port_rdata,
   output logic                        o_mem_req,
   output logic                        o_mem_wren,
   output logic [ADDR_W-1:0]           o_mem_address,
   output logic [DATA_W-1:0]           o_mem_wdata,
   input  logic                        i_mem_ready,
   input  logic [DATA_W-1:0]           i_mem_rdata,
   output logic [GW-1:0]               o_grant_id,
   output logic                        o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DONE
   } state_t;

   state_t                r_state;
   state_t                w_nextState;

   logic [GW-1:0]         r_grant;
   logic [GW-1:0]         r_lastGrant;
   logic                  r_memReq;
   logic                  r_memWren;
   logic [ADDR_W-1:0]     r_memAddr;
   logic [DATA_W-1:0]     r_memWdata;
   logic [DATA_W-1:0]     r_portRdata;
   logic [NUM_PORTS-1:0]  r_portReady;
   logic                  r_busy;

   logic                  w_anyReq;
   logic                  w_found;
   logic [GW-1:0]         w_winner;
   logic [GW:0]           w_idx;
   logic [ADDR_W-1:0]     w_addrArr [NUM_PORTS];
   logic [DATA_W-1:0]     w_wdataArr[NUM_PORTS];

   // Unpack the flat port buses so the winner can be selected by index.
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
      assign w_addrArr[g]  = i_port_address[g*ADDR_W +: ADDR_W];
      assign w_wdataArr[g] = i_port_wdata[g*DATA_W +: DATA_W];
   end

   // Winner search. Round-robin starts one past the last grant and wraps;
   // the candidate index is kept one bit wider so the wrap is a single
   // conditional subtract rather than a modulo.
   always_comb begin
      w_anyReq = |i_port_req;
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (RR_MODE != 0) begin
            w_idx = {1'b0, r_lastGrant} + (GW+1)'(k + 1);
            if (w_idx >= (GW+1)'(NUM_PORTS)) begin
               w_idx = w_idx - (GW+1)'(NUM_PORTS);
            end
         end else begin
            w_idx = (GW+1)'(k);
         end
         if (!w_found && i_port_req[w_idx[GW-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[GW-1:0];
         end
      end
   end

   // Next-state logic. A granted transfer always runs to completion, even
   // if the requester drops req, and mem_ready only counts while issuing.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:  if (w_anyReq)    w_nextState = ST_ISSUE;
         ST_ISSUE: if (i_mem_ready) w_nextState = ST_DONE;
         ST_DONE:                   w_nextState = ST_IDLE;
         default:                   w_nextState = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Datapath and registered outputs. mem_req and busy are computed from the
   // next state so they change on the same edge as the state itself.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_grant     <= '0;
         r_lastGrant <= GW'(NUM_PORTS - 1);
         r_memReq    <= 1'b0;
         r_memWren   <= 1'b0;
         r_memAddr   <= '0;
         r_memWdata  <= '0;
         r_portRdata <= '0;
         r_portReady <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_portReady <= '0;
         r_memReq    <= (w_nextState == ST_ISSUE);
         r_busy      <= (w_nextState != ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               if (w_anyReq) begin
                  r_grant     <= w_winner;
                  r_lastGrant <= w_winner;
                  r_memWren   <= i_port_wren[w_winner];
                  r_memAddr   <= w_addrArr[w_winner];
                  r_memWdata  <= w_wdataArr[w_winner];
               end
            end
            ST_ISSUE: begin
               if (i_mem_ready) begin
                  if (!r_memWren) begin
                     r_portRdata <= i_mem_rdata;
                  end
                  r_portReady <= NUM_PORTS'(1) << r_grant;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_port_ready  = r_portReady;
   assign o_port_rdata  = r_portRdata;
   assign o_mem_req     = r_memReq;
   assign o_mem_wren    = r_memWren;
   assign o_mem_address = r_memAddr;
   assign o_mem_wdata   = r_memWdata;
   assign o_grant_id    = r_grant;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives a fixed-priority and a round-robin four-port arbiter with random
// requesters and a random-latency controller, one instance at a time.
// Expected outputs come from a transaction-level model: the bench knows when
// it granted (first idle edge with any request), when it let the controller
// finish, and derives every output from those event times and the
// arbitration rule.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int NP = 4;
   localparam int AW = 14;
   localparam int DW = 64;
   localparam int GW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstN   [2];
   logic [NP-1:0] req    [2];
   logic [NP-1:0] wren   [2];
   logic [NP*AW-1:0] addr  [2];
   logic [NP*DW-1:0] wdata [2];
   logic [NP-1:0] pReady [2];
   logic [DW-1:0] pRdata [2];
   logic          mReq   [2];
   logic          mWren  [2];
   logic [AW-1:0] mAddr  [2];
   logic [DW-1:0] mWdata [2];
   logic          mReady [2];
   logic [DW-1:0] mRdata [2];
   logic [GW-1:0] grant  [2];
   logic          busy   [2];

   mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) dutFixed (
      .i_clk(clk), .i_rst_n(rstN[0]),
      .i_port_req(req[0]), .i_port_wren(wren[0]),
      .i_port_address(addr[0]), .i_port_wdata(wdata[0]),
      .o_port_ready(pReady[0]), .o_port_rdata(pRdata[0]),
      .o_mem_req(mReq[0]), .o_mem_wren(mWren[0]),
      .o_mem_address(mAddr[0]), .o_mem_wdata(mWdata[0]),
      .i_mem_ready(mReady[0]), .i_mem_rdata(mRdata[0]),
      .o_grant_id(grant[0]), .o_busy(busy[0])
   );

   mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) dutRr (
      .i_clk(clk), .i_rst_n(rstN[1]),
      .i_port_req(req[1]), .i_port_wren(wren[1]),
      .i_port_address(addr[1]), .i_port_wdata(wdata[1]),
      .o_port_ready(pReady[1]), .o_port_rdata(pRdata[1]),
      .o_mem_req(mReq[1]), .o_mem_wren(mWren[1]),
      .o_mem_address(mAddr[1]), .o_mem_wdata(mWdata[1]),
      .i_mem_ready(mReady[1]), .i_mem_rdata(mRdata[1]),
      .o_grant_id(grant[1]), .o_busy(busy[1])
   );

   int checks = 0;
   int passes = 0;

   // Requester-held commands and controller stimulus for the next edge.
   bit            hReq  [NP];
   bit            hWren [NP];
   logic [AW-1:0] hAddr [NP];
   logic [DW-1:0] hData [NP];
   bit            memReadyNext;
   logic [DW-1:0] rdataNext;

   // Transaction-level reference state.
   int            rrMode;
   int            cyc = 0;
   bit            active;
   int            gEdge, rEdge, freeEdge;
   int            win, lastGrant, expGrant, txnIdx;
   bit            txnWren;
   logic [AW-1:0] txnAddr;
   logic [DW-1:0] txnData;
   logic [DW-1:0] expRdata;
   int            waitCnt [NP];

   // Single comparison point: counts, and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Arbitration rule: lowest index, or first request after the last grant.
   function automatic int pick(input logic [NP-1:0] r, input int last, input int rr);
      for (int k = 0; k < NP; k++) begin
         int p;
         p = (rr != 0) ? (last + 1 + k) % NP : k;
         if (r[p]) return p;
      end
      return -1;
   endfunction

   task automatic newCommand(input int p);
      hReq[p]    = 1'b1;
      hWren[p]   = bit'($urandom_range(0, 1));
      hAddr[p]   = AW'($urandom);
      hData[p]   = {$urandom, $urandom};
      waitCnt[p] = 0;
   endtask

   task automatic applyStimulus(input int d);
      for (int p = 0; p < NP; p++) begin
         req[d][p]            = hReq[p];
         wren[d][p]           = hWren[p];
         addr[d][p*AW +: AW]  = hAddr[p];
         wdata[d][p*DW +: DW] = hData[p];
      end
      mReady[d] = memReadyNext;
      mRdata[d] = rdataNext;
   endtask

   task automatic modelReset();
      active    = 1'b0;
      lastGrant = NP - 1;
      expGrant  = 0;
      expRdata  = '0;
      freeEdge  = 0;
      for (int p = 0; p < NP; p++) waitCnt[p] = 0;
   endtask

   // One clock: update the model for the edge, compare, choose next inputs.
   task automatic stepCycle(input int d);
      logic [NP-1:0] sReq;
      logic [DW-1:0] sRd;
      logic [NP-1:0] expReady;
      bit            expReq;
      int            g;
      for (int p = 0; p < NP; p++) sReq[p] = hReq[p];
      sRd = rdataNext;
      @(posedge clk);
      cyc++;
      #1;
      if (active && cyc == rEdge && !txnWren) expRdata = sRd;
      if (active && cyc == rEdge + 1) begin
         active   = 1'b0;
         freeEdge = cyc + 1;
         txnIdx++;
      end
      if (!active && cyc >= freeEdge && sReq != '0) begin
         win       = pick(sReq, lastGrant, rrMode);
         lastGrant = win;
         expGrant  = win;
         active    = 1'b1;
         gEdge     = cyc;
         txnWren   = hWren[win];
         txnAddr   = hAddr[win];
         txnData   = hData[win];
         rEdge     = cyc + ((txnIdx == 0) ? 5 : int'($urandom_range(1, 6)));
         if (rrMode != 0) begin
            g = int'(grant[d]);
            checkOutput("rrWaitBound", 64'(waitCnt[g] <= 3), 64'(1));
            for (int p = 0; p < NP; p++) if (p != g && sReq[p]) waitCnt[p]++;
            waitCnt[g] = 0;
         end
      end
      expReq   = active && (cyc < rEdge);
      expReady = '0;
      if (active && cyc == rEdge) expReady = NP'(1) << win;

      checkOutput("busy",      64'(busy[d]),   64'(active));
      checkOutput("memReq",    64'(mReq[d]),   64'(expReq));
      checkOutput("portReady", 64'(pReady[d]), 64'(expReady));
      checkOutput("portRdata", pRdata[d],      expRdata);
      checkOutput("grantId",   64'(grant[d]),  64'(expGrant));
      if (expReq) begin
         checkOutput("memAddr", 64'(mAddr[d]), 64'(txnAddr));
         checkOutput("memWren", 64'(mWren[d]), 64'(txnWren));
         if (txnWren) checkOutput("memWdata", mWdata[d], txnData);
      end

      // Controller: finish on the chosen edge, random noise outside ISSUE.
      memReadyNext = 1'b0;
      rdataNext    = {$urandom, $urandom};
      if (active && cyc + 1 == rEdge) begin
         memReadyNext = 1'b1;
         if (txnIdx == 0) rdataNext = 64'hDEAD_BEEF_CAFE_F00D;
      end else if (!(active && cyc + 1 < rEdge)) begin
         memReadyNext = ($urandom_range(0, 5) == 0);
      end

      // Requesters: directed read then write, then random traffic.
      if (active && cyc == rEdge) begin
         if (txnIdx == 0) begin
            hReq[1]  = 1'b0;
            hReq[0]  = 1'b1;
            hWren[0] = 1'b1;
            hAddr[0] = 14'h3FFF;
            hData[0] = 64'h1111_2222_3333_4444;
         end else if (txnIdx == 1) begin
            hReq[0] = 1'b0;
         end else if ($urandom_range(0, 3) != 0) begin
            newCommand(win);
         end else begin
            hReq[win] = 1'b0;
         end
      end
      if (active && cyc == gEdge && txnIdx >= 2 && $urandom_range(0, 9) == 0) hReq[win] = 1'b0;
      if (txnIdx >= 2) begin
         for (int p = 0; p < NP; p++) begin
            if (!hReq[p] && !(active && p == win) && $urandom_range(0, 2) == 0) newCommand(p);
         end
      end
      applyStimulus(d);
   endtask

   // Reset while a transfer is issuing, then restart with ports 0 and 2.
   task automatic midResetTest(input int d);
      int guard;
      guard = 0;
      while (!(active && cyc + 1 < rEdge) && guard < 300) begin
         stepCycle(d);
         guard++;
      end
      checkOutput("rstReachIssue", 64'(guard < 300), 64'(1));
      #3;
      checkOutput("preRstMemReq", 64'(mReq[d]), 64'(1));
      rstN[d] = 1'b0;
      #1;
      checkOutput("rstMemReq",    64'(mReq[d]),   64'(0));
      checkOutput("rstBusy",      64'(busy[d]),   64'(0));
      checkOutput("rstPortReady", 64'(pReady[d]), 64'(0));
      checkOutput("rstGrant",     64'(grant[d]),  64'(0));
      checkOutput("rstMemAddr",   64'(mAddr[d]),  64'(0));
      checkOutput("rstMemWren",   64'(mWren[d]),  64'(0));
      checkOutput("rstMemWdata",  mWdata[d],      64'(0));
      checkOutput("rstPortRdata", pRdata[d],      64'(0));
      for (int p = 0; p < NP; p++) hReq[p] = 1'b0;
      newCommand(0);
      newCommand(2);
      memReadyNext = 1'b0;
      applyStimulus(d);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN[d] = 1'b1;
      modelReset();
      stepCycle(d);
      checkOutput("rstFirstGrant", 64'(grant[d]), 64'(0));
      checkOutput("rstFirstReq",   64'(mReq[d]),  64'(1));
   endtask

   task automatic runInstance(input int d);
      rrMode = d;
      modelReset();
      txnIdx = 0;
      for (int p = 0; p < NP; p++) begin
         hReq[p] = 1'b0; hWren[p] = 1'b0; hAddr[p] = '0; hData[p] = '0;
      end
      hReq[1]  = 1'b1;
      hAddr[1] = 14'h0123;
      hData[1] = {$urandom, $urandom};
      memReadyNext = 1'b0;
      rdataNext    = '0;
      applyStimulus(d);
      repeat (1200) stepCycle(d);
      checkOutput("progress", 64'(txnIdx > 50), 64'(1));
      midResetTest(d);
      repeat (60) stepCycle(d);
   endtask

   initial begin
      for (int p = 0; p < NP; p++) begin
         hReq[p] = 1'b0; hWren[p] = 1'b0; hAddr[p] = '0; hData[p] = '0;
      end
      memReadyNext = 1'b0;
      rdataNext    = '0;
      for (int d = 0; d < 2; d++) begin
         rstN[d] = 1'b0;
         applyStimulus(d);
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checkOutput("initBusy",      64'(busy[d]),   64'(0));
         checkOutput("initMemReq",    64'(mReq[d]),   64'(0));
         checkOutput("initPortReady", 64'(pReady[d]), 64'(0));
         checkOutput("initPortRdata", pRdata[d],      64'(0));
         checkOutput("initGrant",     64'(grant[d]),  64'(0));
         checkOutput("initMemAddr",   64'(mAddr[d]),  64'(0));
      end
      @(negedge clk);
      rstN[0] = 1'b1;
      rstN[1] = 1'b1;
      for (int d = 0; d < 2; d++) begin
         $display("[TB] running instance %0d (%s)", d, (d == 0) ? "fixed priority" : "round-robin");
         runInstance(d);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-port arbiter that sits between the cache controllers (program cache, data cache, and future video/DMA ports) and the single SDRAM controller line-transfer interface. Generalises the current fixed two-port p1/p2 arrangement to NUM_PORTS requesters with selectable fixed-priority or round-robin arbitration. Each port uses the existing req/ready line-transfer handshake, so caches connect unchanged. Read data is registered and broadcast, and the grant is exposed for debug and bench probing.

## Interface
- NUM_PORTS, 2, number of requesting ports (2..8)
- ADDR_W, 14, line address width
- DATA_W, 64, line data width
- RR_MODE, 1, 0 = fixed priority (port 0 highest), 1 = round-robin
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- port_req  in  NUM_PORTS  per-port request, level
- port_wren  in  NUM_PORTS  per-port write (1) / read (0)
- port_address  in  NUM_PORTS*ADDR_W  packed line addresses, port i at [i*ADDR_W +: ADDR_W]
- port_wdata  in  NUM_PORTS*DATA_W  packed write lines
- port_ready  out  NUM_PORTS  one-cycle completion pulse, one-hot or zero
- port_rdata  out  DATA_W  registered read line, valid while the matching port_ready is high
- mem_req  out  1  request to SDRAM controller
- mem_wren  out  1  write flag to controller
- mem_address  out  ADDR_W  line address to controller
- mem_wdata  out  DATA_W  write line to controller
- mem_ready  in  1  controller completion pulse, carries mem_rdata for reads
- mem_rdata  in  DATA_W  read line from controller
- grant_id  out  max(1,clog2(NUM_PORTS))  index of the current or last granted port
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: if any port_req is set, select a winner, latch its index, wren, address and wdata into registers, go to ISSUE; otherwise stay in IDLE.
  - ISSUE: hold mem_req=1 with the latched command; on mem_ready, capture mem_rdata (reads only), go to DONE.
  - DONE: pulse port_ready[grant_id] for one cycle, go to IDLE.
- Fixed mode: the lowest-index active request wins.
- Round-robin mode:
  - Search starts at last_grant+1 and wraps modulo NUM_PORTS.
  - last_grant updates when a grant is made.
  - last_grant resets to NUM_PORTS-1, so port 0 is searched first after reset.
- Requester rule: the requester holds req, wren, address and wdata stable from req assertion until its ready pulse, then deasserts req on the next cycle.
- The DONE cycle is the turnaround that lets the requester deassert req.
- A port whose req drops while granted is still completed: command already latched, ready still pulsed. Never abort.
- port_rdata is unchanged on writes (holds the last read line).
- mem_ready in IDLE or DONE is ignored.
- Reset (asserted anywhere, including mid-transaction) forces:
  - state=IDLE
  - mem_req=0, mem_wren=0, mem_address=0, mem_wdata=0
  - port_ready=0, port_rdata=0
  - grant_id=0, busy=0
  - rr pointer=NUM_PORTS-1
- After reset, the controller must be reset with the arbiter. An in-flight SDRAM transfer is abandoned.

## Timing
- Request seen in IDLE at edge t: mem_req=1 from t+1.
- mem_ready sampled high at edge t+k: port_ready high during cycle t+k+1, then low.
- Earliest next grant: IDLE at t+k+2, mem_req again at t+k+3.
- Minimum transaction with a one-cycle controller (mem_ready at t+1): 3 cycles per transfer, back-to-back.
- All outputs are registered; no combinational path from port inputs or mem_ready to any output.
- A request that arrives while busy waits until IDLE. There is no queueing beyond the held req level.

## Test plan
- Single read: NUM_PORTS=2, port 1 requests address 0x0123 with wren=0; controller returns 0xDEADBEEF_CAFEF00D after 5 cycles.
  - Required: mem_address=0x0123, mem_wren=0.
  - Required: port_ready=2'b10 for exactly one cycle, with port_rdata=0xDEADBEEF_CAFEF00D.
- Write: port 0 writes 0x1111_2222_3333_4444 to 0x3FFF.
  - Required: mem_wren=1 and mem_wdata matches.
  - Required: port_ready=2'b01 pulses once; port_rdata is unchanged from its prior value.
- Fixed priority: RR_MODE=0, NUM_PORTS=4, ports 0..3 all hold req continuously.
  - Required grant sequence: 0,0,0… while port 0 keeps requesting.
  - After port 0 deasserts, required grant sequence: 1 then 1…
- Round-robin fairness: RR_MODE=1, NUM_PORTS=4, all four ports re-request immediately after each ready.
  - Required grant_id sequence: 0,1,2,3,0,1…
  - Required: no port waits more than 3 transactions.
- Reset mid-transaction: assert reset while in ISSUE with mem_req=1.
  - Required: mem_req=0 and busy=0 asynchronously, before the next edge.
  - Required after release with ports 0 and 2 requesting: first grant is port 0 (both modes).
- Dropped request: port 1 deasserts req one cycle after the grant.
  - Required: transaction still issues to the controller and port_ready[1] still pulses once.
  - Required: the arbiter returns to IDLE with busy=0.
